// File: rtl/swim_pkg.sv
// Shared definitions for the SWIM low-speed frame transmitter.
// Provides the bit timing constants (in 48 MHz clk cycles), the SWIM
// command codes, the transmitter state encoding and a helper that builds
// the left-aligned on-wire frame from a payload.
package swim_pkg;

    localparam int SHORT_CYC   = 12;    // 2 SWIM clocks at 8 MHz HSI
    localparam int LONG_CYC    = 120;   // 20 SWIM clocks
    localparam int SAMPLE_CYC  = 66;    // ACK sample point after its falling edge
    localparam int ACK_TIMEOUT = 2048;  // wait budget for the target's ACK edge

    // One counter serves every phase, so it is sized for the longest one.
    localparam int CNT_W = $clog2((LONG_CYC > ACK_TIMEOUT) ? LONG_CYC : ACK_TIMEOUT);

    localparam logic [2:0] SRST = 3'b000;
    localparam logic [2:0] ROTF = 3'b001;
    localparam logic [2:0] WOTF = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_ACK_WAIT,
        ST_ACK_SAMPLE,
        ST_ACK_END,
        ST_DONE
    } state_e;

    // Header 0, payload MSB first, even parity; left-aligned in 10 bits so
    // the bit on the wire is always bit 9 of the shift register.
    function automatic logic [9:0] build_frame(input logic [7:0] data, input logic is_cmd);
        if (is_cmd) begin
            return {1'b0, data[2:0], ^data[2:0], 5'b00000};
        end
        return {1'b0, data, ^data};
    endfunction

endpackage

// File: rtl/swim_frame_tx_sync.sv
// Two-flop synchroniser and falling-edge detector for the raw SWIM pin.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   swim_in_i  asynchronous pin level
//   line_hi_o  synchronised pin level
//   fall_o     one-cycle pulse on a synchronised 1 -> 0 transition
module swim_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic swim_in_i,
    output logic line_hi_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // The pin idles high through its pull-up, so reset to 1 keeps the edge
    // detector quiet coming out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the three flops sample
            // together, which is what forms the shift chain.
            meta_q <= swim_in_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign line_hi_o = sync_q;
    assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/swim_frame_tx.sv
// SWIM low-speed frame transmitter.
// Serialises a 3-bit command or 8-bit data payload as header + payload +
// parity on the open-drain SWIM pin, then samples the target ACK bit.
// Ports:
//   clk, reset      48 MHz clock, synchronous active-high reset
//   in_data         payload (commands use in_data[2:0])
//   in_is_cmd       1 = command frame, 0 = data frame
//   in_valid/ready  payload handshake
//   swim_in         raw pin level
//   swim_oe         1 = drive pin low
//   res_valid       one-cycle result strobe, with res_ack / res_timeout
//   busy            frame in progress
module swim_frame_tx
    import swim_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_is_cmd,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       swim_in,
    output logic       swim_oe,
    output logic       res_valid,
    output logic       res_ack,
    output logic       res_timeout,
    output logic       busy
);

    logic line_hi;
    logic fall;

    swim_in_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .swim_in_i (swim_in),
        .line_hi_o (line_hi),
        .fall_o    (fall)
    );

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [9:0]       shift_q,     shift_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic             ack_smp_q,   ack_smp_d;
    logic             res_ack_q,   res_ack_d;
    logic             res_tmo_q,   res_tmo_d;
    logic             swim_oe_q;

    logic             cur_bit;
    logic [CNT_W-1:0] lo_last;
    logic [CNT_W-1:0] hi_last;

    // A 1 bit is a short low then a long high; a 0 bit is the reverse.
    assign cur_bit = shift_q[9];
    assign lo_last = cur_bit ? CNT_W'(SHORT_CYC - 1) : CNT_W'(LONG_CYC - 1);
    assign hi_last = cur_bit ? CNT_W'(LONG_CYC - 1)  : CNT_W'(SHORT_CYC - 1);

    assign in_ready = (state_q == ST_IDLE) & line_hi & ~reset;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        ack_smp_d   = ack_smp_q;
        res_ack_d   = res_ack_q;
        res_tmo_d   = res_tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (in_valid && in_ready) begin
                    state_d     = ST_BIT_LO;
                    shift_d     = build_frame(in_data, in_is_cmd);
                    bits_left_d = in_is_cmd ? 4'd5 : 4'd10;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == lo_last) begin
                    state_d = ST_BIT_HI;
                    cnt_d   = '0;
                end
            end
            ST_BIT_HI: begin
                if (cnt_q == hi_last) begin
                    cnt_d = '0;
                    if (bits_left_q == 4'd1) begin
                        state_d = ST_ACK_WAIT;
                    end else begin
                        state_d     = ST_BIT_LO;
                        shift_d     = {shift_q[8:0], 1'b0};
                        bits_left_d = bits_left_q - 1'b1;
                    end
                end
            end
            ST_ACK_WAIT: begin
                if (fall) begin
                    state_d = ST_ACK_SAMPLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    res_ack_d = 1'b0;
                    res_tmo_d = 1'b1;
                end
            end
            ST_ACK_SAMPLE: begin
                // A short ACK pulse has ended by now; a NACK still holds low.
                if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
                    state_d   = ST_ACK_END;
                    cnt_d     = '0;
                    ack_smp_d = line_hi;
                end
            end
            ST_ACK_END: begin
                if (line_hi) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    res_ack_d = ack_smp_q;
                    res_tmo_d = 1'b0;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    res_ack_d = 1'b0;
                    res_tmo_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            bits_left_q <= '0;
            ack_smp_q   <= 1'b0;
            res_ack_q   <= 1'b0;
            res_tmo_q   <= 1'b0;
            swim_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            ack_smp_q   <= ack_smp_d;
            res_ack_q   <= res_ack_d;
            res_tmo_q   <= res_tmo_d;
            // Registered from the next state so the pin driver never sees a
            // decode glitch; it still switches on the same edge as the state.
            swim_oe_q   <= (state_d == ST_BIT_LO);
        end
    end

    assign swim_oe     = swim_oe_q;
    assign res_valid   = (state_q == ST_DONE);
    assign res_ack     = res_ack_q;
    assign res_timeout = res_tmo_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_swim_frame_tx.sv
// Self-checking bench for swim_frame_tx: a stimulus process issues frames and
// plays the target; a monitor decodes the pin and checks results against a
// scoreboard of expected bits and results.
module tb_swim_frame_tx;
    import swim_pkg::*;

    typedef enum {R_ACK, R_NACK, R_NONE, R_RESET} resp_e;
    typedef struct {
        logic ack;
        logic tmo;
        bit   chk_lat;
        int   lat;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_is_cmd = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       swim_in;
    logic       swim_oe;
    logic       res_valid;
    logic       res_ack;
    logic       res_timeout;
    logic       busy;
    logic       tgt_low = 1'b0;

    // Open-drain wire: low if either the DUT or the target pulls it.
    assign swim_in = ~(swim_oe | tgt_low);

    swim_frame_tx dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_is_cmd   (in_is_cmd),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .swim_in     (swim_in),
        .swim_oe     (swim_oe),
        .res_valid   (res_valid),
        .res_ack     (res_ack),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    bit     exp_bits[$];
    res_t   exp_res[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: decodes swim_oe pulses into bits and checks results.
    initial begin : monitor
        logic   oe_prev;
        logic   b;
        logic   prev_bit;
        int     low_len;
        int     hi_len;
        int     nbit;
        longint last_fall;
        res_t   r;
        oe_prev = 1'b0; prev_bit = 1'b0; low_len = 0; hi_len = 0; nbit = 0; last_fall = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                oe_prev = 1'b0; low_len = 0; hi_len = 0; nbit = 0;
                continue;
            end
            if (swim_oe) begin
                if (!oe_prev) begin
                    if (nbit > 0) check("bit_gap", hi_len, prev_bit ? LONG_CYC : SHORT_CYC);
                    low_len = 0;
                end
                low_len++;
            end else begin
                if (oe_prev) begin
                    b = (low_len == SHORT_CYC);
                    check("pulse_len", (low_len == SHORT_CYC) || (low_len == LONG_CYC), 1);
                    check("bit_expected", exp_bits.size() != 0, 1);
                    if (exp_bits.size() != 0) check("bit_value", b, exp_bits.pop_front());
                    prev_bit = b; nbit++; last_fall = cyc; hi_len = 0;
                end
                hi_len++;
            end
            oe_prev = swim_oe;
            if (res_valid) begin
                nbit = 0;
                check("result_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) begin
                    r = exp_res.pop_front();
                    check("res_ack", res_ack, r.ack);
                    check("res_timeout", res_timeout, r.tmo);
                    if (r.chk_lat) check("timeout_latency", 32'(cyc - last_fall), r.lat);
                end
            end
        end
    end

    // Caller must be at a negedge. Builds the expected frame from the payload
    // rules and performs the handshake; returns at the negedge after it.
    task automatic handshake(input logic [7:0] d, input logic is_cmd, input resp_e mode,
                             output int nbits, output bit par);
        int   n;
        int   ones;
        int   guard;
        res_t r;
        in_data = d; in_is_cmd = is_cmd; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        nbits = 0; par = 1'b0;
        if (!in_ready) begin
            check("in_ready_wait", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        n = is_cmd ? 3 : 8;
        ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = n - 1; i >= 0; i--) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        par = bit'(ones % 2);
        exp_bits.push_back(par);
        nbits = n + 2;
        r.ack = (mode == R_ACK); r.tmo = (mode == R_NONE);
        r.chk_lat = (mode == R_NONE);
        r.lat = (par ? LONG_CYC : SHORT_CYC) + ACK_TIMEOUT;
        if (mode != R_RESET) exp_res.push_back(r);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("start_oe", swim_oe, 1);
        check("start_busy", busy, 1);
    endtask

    // Waits out the bits (optionally toggling the input), plays the target's
    // ACK response, then waits for the frame to finish.
    task automatic finish_frame(input int nbits, input bit par, input resp_e mode, input bit toggle);
        int   falls;
        int   guard;
        bit   leak;
        logic oe_last;
        falls = 0; guard = 0; leak = 1'b0; oe_last = swim_oe;
        while (falls < nbits && guard < nbits * (SHORT_CYC + LONG_CYC) + 50) begin
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
                in_is_cmd = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
            if (in_ready) leak = 1'b1;
            if (oe_last && !swim_oe) falls++;
            oe_last = swim_oe;
        end
        in_valid = 1'b0;
        check("frame_bit_count", falls, nbits);
        if (mode == R_ACK || mode == R_NACK) begin
            repeat ((par ? LONG_CYC : SHORT_CYC) + SHORT_CYC) @(negedge clk);
            tgt_low = 1'b1;
            repeat ((mode == R_ACK) ? SHORT_CYC : LONG_CYC) @(negedge clk);
            tgt_low = 1'b0;
        end
        guard = 0;
        while (busy && guard < ACK_TIMEOUT + 1000) begin
            @(negedge clk);
            guard++;
            if (in_ready && busy) leak = 1'b1;
        end
        check("frame_done", busy, 0);
        check("in_ready_while_busy", leak, 0);
        if (mode == R_ACK) check("res_ack_hold", res_ack, 1);
        if (mode == R_NONE) check("res_timeout_hold", res_timeout, 1);
    endtask

    initial begin : watchdog
        #10ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int    nb;
        bit    p;
        int    rises;
        int    guard;
        bit    bad_rdy;
        bit    bad_oe;
        resp_e m;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_swim_oe", swim_oe, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ack", res_ack, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Data 0xA5, target ACKs
        handshake(8'hA5, 1'b0, R_ACK, nb, p);
        finish_frame(nb, p, R_ACK, 1'b0);

        // Command WOTF, target NACKs
        handshake({5'b0, WOTF}, 1'b1, R_NACK, nb, p);
        finish_frame(nb, p, R_NACK, 1'b0);

        // No response from the target
        handshake({5'b0, ROTF}, 1'b1, R_NONE, nb, p);
        finish_frame(nb, p, R_NONE, 1'b0);

        // Line held low in IDLE: frame refused until release
        tgt_low = 1'b1;
        in_data = 8'h3C; in_is_cmd = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        bad_rdy = 1'b0; bad_oe = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad_rdy = 1'b1;
            if (swim_oe !== 1'b0) bad_oe = 1'b1;
        end
        check("held_low_in_ready", bad_rdy, 0);
        check("held_low_swim_oe", bad_oe, 0);
        tgt_low = 1'b0;
        @(negedge clk);
        check("release_in_ready_1", in_ready, 0);
        @(negedge clk);
        check("release_in_ready_2", in_ready, 1);
        handshake(8'h3C, 1'b0, R_ACK, nb, p);
        finish_frame(nb, p, R_ACK, 1'b0);

        // Reset during the 4th bit low phase
        handshake(8'h3C, 1'b0, R_RESET, nb, p);
        rises = 1; guard = 0;
        begin
            logic oe_l;
            oe_l = swim_oe;
            while (rises < 4 && guard < 2000) begin
                @(negedge clk);
                guard++;
                if (!oe_l && swim_oe) rises++;
                oe_l = swim_oe;
            end
        end
        check("reach_bit4", rises, 4);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_bits.delete();
        @(posedge clk);
        #1;
        check("midrst_swim_oe", swim_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_res_valid", res_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        handshake(8'h00, 1'b0, R_ACK, nb, p);
        finish_frame(nb, p, R_ACK, 1'b0);

        // In_valid toggled during a frame is ignored
        handshake(8'h5A, 1'b0, R_ACK, nb, p);
        finish_frame(nb, p, R_ACK, 1'b1);

        // Randomised frames
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       m = R_NONE;
                1:       m = R_NACK;
                default: m = R_ACK;
            endcase
            handshake(8'($urandom), 1'($urandom_range(0, 1)), m, nb, p);
            finish_frame(nb, p, m, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("exp_bits_drained", exp_bits.size(), 0);
        check("exp_results_drained", exp_res.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/swim_frame_tx.md
Name: swim_frame_tx

Overview:
- Drives STM8 SWIM low-speed frames on the open-drain SWIM pin.
- Sits downstream of the USB-UART byte FIFO and of the SWIM reset-sequence generator; the two share the pin through an external OR of the low-drive enables.
- Accepts one 3-bit command or one 8-bit data payload per handshake and serialises it as header + payload + parity, then samples the target ACK bit.
- Reports ACK, NACK or timeout to the upstream controller.

Parameters:
- SHORT_CYC, 12, clk cycles of the short phase of a bit (2 SWIM clocks at 48 MHz / 8 MHz HSI)
- LONG_CYC, 120, clk cycles of the long phase of a bit (20 SWIM clocks)
- SAMPLE_CYC, 66, clk cycles after the ACK falling edge at which the line is sampled
- ACK_TIMEOUT, 2048, clk cycles allowed after the parity bit for the target's falling edge

Ports:
- clk  in  1  48 MHz system clock
- reset  in  1  synchronous, active-high
- in_data  in  8  payload; command uses in_data[2:0]
- in_is_cmd  in  1  1 = 3-bit command frame, 0 = 8-bit data frame
- in_valid  in  1  payload valid
- in_ready  out  1  block can accept a payload
- swim_in  in  1  raw asynchronous SWIM pin level
- swim_oe  out  1  1 = drive pin low; 0 = release (pull-up)
- res_valid  out  1  one-cycle result strobe
- res_ack  out  1  target ACKed (valid with res_valid)
- res_timeout  out  1  no ACK edge seen (valid with res_valid)
- busy  out  1  frame in progress

Behaviour:
- Input sync: swim_in passes through a 2-flop synchroniser. line_hi is the synchronised level; fall is line_hi(prev)=1 and line_hi=0.
- Reset: state IDLE, swim_oe=0, res_valid=0, res_ack=0, res_timeout=0, busy=0, in_ready=0 while reset is high. Reset mid-frame releases the pin on the next edge and drops the frame without a result.
- Acceptance:
  - in_ready = (state==IDLE) & line_hi & ~reset. The block refuses frames while the target holds the line low.
  - Handshake on in_valid & in_ready at edge T. From T+1, busy=1 and swim_oe=1 (first bit low phase).
- Frame bits, in order:
  - header 0
  - payload MSB first: in_data[2:0] for a command, in_data[7:0] for data
  - even parity bit = XOR of the payload bits
  - Total 5 bits for a command, 10 bits for data. The payload is latched at the handshake.
- Bit encoding, BIT_CYC = SHORT_CYC + LONG_CYC:
  - bit 0: swim_oe=1 for LONG_CYC, then 0 for SHORT_CYC
  - bit 1: swim_oe=1 for SHORT_CYC, then 0 for LONG_CYC
  - Bits are back-to-back with no gap.
- States:
  - IDLE -> BIT_LO on handshake
  - BIT_LO -> BIT_HI when the phase counter expires
  - BIT_HI -> BIT_LO for the next bit, or -> ACK_WAIT after the parity bit
  - ACK_WAIT: swim_oe=0; the counter runs. On fall -> ACK_SAMPLE, counter cleared. When the counter reaches ACK_TIMEOUT-1 -> DONE with timeout.
  - ACK_SAMPLE: at SAMPLE_CYC cycles after fall, latch ack = line_hi (1 = ACK, 0 = NACK), then -> ACK_END.
  - ACK_END: wait for line_hi=1 -> DONE. Guard of ACK_TIMEOUT cycles; on expiry -> DONE with timeout=1, ack=0.
  - DONE: res_valid=1 for exactly one cycle with res_ack and res_timeout, then -> IDLE. busy=0 in IDLE only.
- Flags: res_ack and res_timeout are never both 1. They hold their value until the next res_valid.
- Counter width: a counter of clog2(max(LONG_CYC, ACK_TIMEOUT)) bits covers all phases; it is cleared on every state change.
- Handshake timing: in_valid asserted while busy is ignored and not queued. A new frame can be accepted the cycle after the res_valid cycle.
- Latency: res_valid occurs nbits*BIT_CYC + ack time + 1..2 cycles after the handshake.

Decomposition:
- Package swim_pkg:
  - timing constants SHORT_CYC, LONG_CYC, SAMPLE_CYC, ACK_TIMEOUT
  - command codes SRST=3'b000, ROTF=3'b001, WOTF=3'b010
  - state enum
- One sub-module, swim_in_sync: 2-flop synchroniser plus falling-edge detector producing line_hi and fall.

Test Plan:
- Data 0xA5, target ACKs (pulls low 12 cycles after release) -> swim_oe pattern bits 0,1,0,1,0,0,1,0,1,0 (parity 0). Each 0 is 120 low + 12 high. Then res_valid, res_ack=1, res_timeout=0.
- Command WOTF 3'b010 -> 5 bits 0,0,1,0,1 (parity 1), total 660 cycles of drive. Target NACK (holds low 120 cycles) -> res_ack=0, res_timeout=0.
- No target response after the parity bit -> res_valid exactly 2048 cycles after entering ACK_WAIT, with res_timeout=1 and res_ack=0.
- swim_in held low in IDLE, in_valid=1 -> in_ready stays 0 and swim_oe stays 0. Release the line -> in_ready=1 two cycles later and the frame starts.
- Reset asserted during the 4th bit low phase -> swim_oe=0 on the next edge, no res_valid. After deassertion a new 0x00 frame transmits correctly.
- in_valid toggled during a frame with different data -> ignored. Only the latched payload appears on the line, and in_ready stays 0 until after res_valid.
